// File: rtl/mouse_sprite_ctrl.sv
// Mouse sprite controller: sequences sprite-RAM clear/stream-load writes and
// double-buffers the sprite origin so it only moves at frame start.
module mouse_sprite_ctrl #(
  parameter int unsigned CD = 12,
  parameter int unsigned ADDR = 12,
  parameter logic [CD-1:0] KEY_COLOR = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_clear,
  input  logic            cmd_load,
  input  logic            cmd_abort,
  input  logic            s_valid,
  input  logic [CD-1:0]   s_data,
  output logic            s_ready,
  input  logic            pos_we,
  input  logic [10:0]     pos_x_in,
  input  logic [10:0]     pos_y_in,
  input  logic            frame_start,
  output logic            we,
  output logic [ADDR-1:0] addr_w,
  output logic [CD-1:0]   pixel_out,
  output logic [10:0]     x0,
  output logic [10:0]     y0,
  output logic            busy,
  output logic            done
);

  localparam int unsigned CW = ADDR + 1;
  localparam int unsigned POS_W = 11;
  localparam logic [CW-1:0] CNT_FULL = CW'(1) << ADDR;
  localparam logic [CW-1:0] CNT_LAST = CNT_FULL - CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              hs;

  logic              we_d, s_ready_d, busy_d, done_d;
  logic [ADDR-1:0]   addr_d;
  logic [CD-1:0]     pixel_d;

  logic [POS_W-1:0]  pend_x, pend_y;
  logic              pend;

  assign hs = s_valid && s_ready;

  // State and counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; in CLEAR cnt is the address on the bus, in LOAD it counts handshakes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (cmd_load) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cmd_abort || cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LOAD: begin
        if (cmd_abort || cnt_q == CNT_FULL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (hs) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    we_d      = 1'b0;
    s_ready_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    addr_d    = addr_w;
    pixel_d   = pixel_out;
    unique case (state_q)
      IDLE: begin
        if (cmd_clear) begin
          we_d    = 1'b1;
          addr_d  = '0;
          pixel_d = KEY_COLOR;
          busy_d  = 1'b1;
        end else if (cmd_load) begin
          s_ready_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      CLEAR: begin
        if (!cmd_abort) begin
          if (cnt_q == CNT_LAST) begin
            done_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            addr_d  = ADDR'(cnt_q + CW'(1));
            pixel_d = KEY_COLOR;
            busy_d  = 1'b1;
          end
        end
      end
      LOAD: begin
        if (!cmd_abort) begin
          if (cnt_q == CNT_FULL) begin
            done_d = 1'b1;
          end else begin
            busy_d    = 1'b1;
            s_ready_d = !(hs && cnt_q == CNT_LAST);
            if (hs) begin
              we_d    = 1'b1;
              addr_d  = ADDR'(cnt_q);
              pixel_d = s_data;
            end
          end
        end
      end
      default: begin
        we_d = 1'b0;
      end
    endcase
  end

  // Output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we        <= 1'b0;
      addr_w    <= '0;
      pixel_out <= '0;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      we        <= we_d;
      addr_w    <= addr_d;
      pixel_out <= pixel_d;
      s_ready   <= s_ready_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Origin double-buffer: a pending value is applied at frame start, a same-cycle write stays pending
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_x <= '0;
      pend_y <= '0;
      pend   <= 1'b0;
      x0     <= '0;
      y0     <= '0;
    end else begin
      if (frame_start && pend) begin
        x0 <= pend_x;
        y0 <= pend_y;
      end
      if (pos_we) begin
        pend_x <= pos_x_in;
        pend_y <= pos_y_in;
        pend   <= 1'b1;
      end else if (frame_start) begin
        pend   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mouse_sprite_ctrl.sv
// Self-checking bench for mouse_sprite_ctrl: expected write streams, done timing
// and origin values are derived from the commands and pixels the bench issues.
module tb_mouse_sprite_ctrl;

  localparam int unsigned CD = 12;
  localparam int unsigned ADDR = 4;
  localparam int NPIX = 1 << ADDR;
  localparam logic [CD-1:0] KEY = 12'hABC;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            cmd_clear, cmd_load, cmd_abort;
  logic            s_valid;
  logic [CD-1:0]   s_data;
  logic            s_ready;
  logic            pos_we;
  logic [10:0]     pos_x_in, pos_y_in;
  logic            frame_start;
  logic            we;
  logic [ADDR-1:0] addr_w;
  logic [CD-1:0]   pixel_out;
  logic [10:0]     x0, y0;
  logic            busy, done;

  mouse_sprite_ctrl #(.CD(CD), .ADDR(ADDR), .KEY_COLOR(KEY)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_clear(cmd_clear), .cmd_load(cmd_load), .cmd_abort(cmd_abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .pos_we(pos_we), .pos_x_in(pos_x_in), .pos_y_in(pos_y_in),
    .frame_start(frame_start),
    .we(we), .addr_w(addr_w), .pixel_out(pixel_out),
    .x0(x0), .y0(y0), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wa[$], wd[$], wt[$], done_t[$];
  int busy_n = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and log what the DUT presented in the new cycle
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (reset_n) begin
      if (we) begin
        wa.push_back(int'(addr_w));
        wd.push_back(int'(pixel_out));
        wt.push_back(cyc);
      end
      if (done) done_t.push_back(cyc);
      if (busy) busy_n++;
    end
  endtask

  task automatic clr_log();
    wa.delete(); wd.delete(); wt.delete(); done_t.delete();
    busy_n = 0;
  endtask

  task automatic check_writes(input string tag, input int exp_d[$]);
    int n;
    chk({tag, "_nwr"}, wa.size(), exp_d.size());
    n = (wa.size() < exp_d.size()) ? wa.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wa[i], i);
      chk($sformatf("%s_data%0d", tag, i), wd[i], exp_d[i]);
    end
  endtask

  task automatic do_clear(input bit with_load, input bit inject_load);
    int ce;
    int exp_d[$];
    int n;
    clr_log();
    cmd_clear = 1'b1; cmd_load = with_load;
    step();
    cmd_clear = 1'b0; cmd_load = 1'b0;
    ce = cyc;
    for (int k = 0; k < 20; k++) begin
      if (inject_load && k == 4) cmd_load = 1'b1;
      step();
      cmd_load = 1'b0;
    end
    for (int i = 0; i < NPIX; i++) exp_d.push_back(int'(KEY));
    check_writes("clr", exp_d);
    n = (wt.size() < NPIX) ? wt.size() : NPIX;
    for (int i = 0; i < n; i++) chk($sformatf("clr_t%0d", i), wt[i], ce + i);
    chk("clr_ndone", done_t.size(), 1);
    if (done_t.size() > 0) chk("clr_done_t", done_t[0], ce + NPIX);
    chk("clr_busy_cycles", busy_n, NPIX);
    chk("clr_ready_idle", s_ready, 0);
  endtask

  task automatic do_load(input int pix[$], input int nacc, input bit rnd_gaps, input bit do_abort);
    int ce, idx, k;
    bit gap;
    int exp_d[$];
    clr_log();
    cmd_load = 1'b1;
    step();
    cmd_load = 1'b0;
    ce = cyc;
    idx = 0; k = 0;
    while (idx < nacc && k < 200) begin
      chk("ld_ready", s_ready, 1);
      gap = rnd_gaps ? ($urandom_range(0, 2) == 0) : (k % 3 == 2);
      s_valid = !gap;
      s_data = CD'(pix[idx]);
      if (!gap) idx++;
      step();
      k++;
    end
    chk("ld_handshakes", idx, nacc);
    if (do_abort) begin
      s_valid = 1'b1; s_data = 12'h5A5; cmd_abort = 1'b1;
      step();
      cmd_abort = 1'b0; s_valid = 1'b0;
      chk("ab_busy", busy, 0);
      chk("ab_we", we, 0);
      chk("ab_ready", s_ready, 0);
      repeat (4) step();
      chk("ab_ndone", done_t.size(), 0);
    end else begin
      s_valid = 1'b0;
      chk("ld_ready_end", s_ready, 0);
      repeat (4) step();
      chk("ld_ndone", done_t.size(), 1);
      if (done_t.size() > 0 && wt.size() > 0) begin
        chk("ld_done_t", done_t[0], wt[wt.size() - 1] + 1);
        chk("ld_busy_cycles", busy_n, done_t[0] - ce);
      end
    end
    for (int i = 0; i < nacc; i++) exp_d.push_back(pix[i] & 32'hFFF);
    check_writes(do_abort ? "ab" : "ld", exp_d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int pix[$];
    int ax, ay, px, py, nx, ny;
    bit pend, pw, fs;

    reset_n = 1'b0;
    cmd_clear = 0; cmd_load = 0; cmd_abort = 0;
    s_valid = 0; s_data = '0;
    pos_we = 0; pos_x_in = '0; pos_y_in = '0; frame_start = 0;
    repeat (3) step();
    chk("rst_we", we, 0);
    chk("rst_addr", addr_w, 0);
    chk("rst_pixel", pixel_out, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_x0", x0, 0);
    chk("rst_y0", y0, 0);
    reset_n = 1'b1;
    step();

    // Abort while idle does nothing
    clr_log();
    cmd_abort = 1'b1; step(); cmd_abort = 1'b0; step();
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_nwr", wa.size(), 0);

    do_clear(1'b0, 1'b0);

    pix.delete();
    for (int i = 0; i < NPIX; i++) pix.push_back(32'h100 + i);
    do_load(pix, NPIX, 1'b0, 1'b0);

    pix.delete();
    for (int i = 0; i < NPIX; i++) pix.push_back(int'($urandom_range(0, 4095)));
    do_load(pix, 5, 1'b0, 1'b1);

    pix.delete();
    for (int i = 0; i < NPIX; i++) pix.push_back(int'($urandom_range(0, 4095)));
    do_load(pix, NPIX, 1'b1, 1'b0);

    do_clear(1'b1, 1'b0);
    do_clear(1'b0, 1'b1);

    // Directed origin double-buffering
    pos_we = 1; pos_x_in = 11'd100; pos_y_in = 11'd200;
    step(); pos_we = 0;
    chk("pos_hold_x", x0, 0);
    chk("pos_hold_y", y0, 0);
    step(); step();
    chk("pos_hold2_x", x0, 0);
    frame_start = 1; step(); frame_start = 0;
    chk("pos_apply_x", x0, 100);
    chk("pos_apply_y", y0, 200);
    pos_we = 1; pos_x_in = 11'd50; pos_y_in = 11'd60;
    step(); pos_we = 0;
    pos_we = 1; pos_x_in = 11'd300; pos_y_in = 11'd40; frame_start = 1;
    step(); pos_we = 0; frame_start = 0;
    chk("pos_same_x", x0, 50);
    chk("pos_same_y", y0, 60);
    step();
    chk("pos_wait_x", x0, 50);
    frame_start = 1; step(); frame_start = 0;
    chk("pos_next_x", x0, 300);
    chk("pos_next_y", y0, 40);
    frame_start = 1; step(); frame_start = 0;
    chk("pos_nopend_x", x0, 300);

    // Random origin traffic while a clear runs
    ax = 300; ay = 40; px = 0; py = 0; pend = 0;
    clr_log();
    cmd_clear = 1'b1;
    for (int k = 0; k < 60; k++) begin
      pw = ($urandom_range(0, 2) == 0);
      fs = ($urandom_range(0, 3) == 0);
      nx = int'($urandom_range(0, 2047));
      ny = int'($urandom_range(0, 2047));
      pos_we = pw; pos_x_in = 11'(nx); pos_y_in = 11'(ny); frame_start = fs;
      if (fs && pend) begin ax = px; ay = py; end
      if (pw) begin px = nx; py = ny; pend = 1; end
      else if (fs) pend = 0;
      step();
      cmd_clear = 1'b0;
      chk("rnd_x0", x0, ax);
      chk("rnd_y0", y0, ay);
    end
    pos_we = 0; frame_start = 0;
    chk("rnd_clr_nwr", wa.size(), NPIX);
    chk("rnd_clr_ndone", done_t.size(), 1);

    pos_we = 1; pos_x_in = 11'd7; pos_y_in = 11'd9;
    step(); pos_we = 0;
    frame_start = 1; step(); frame_start = 0;
    chk("pre_rst_x", x0, 7);
    chk("pre_rst_y", y0, 9);
    pos_we = 1; pos_x_in = 11'd77; pos_y_in = 11'd99;
    step(); pos_we = 0;

    // Reset in the middle of a load
    clr_log();
    cmd_load = 1; step(); cmd_load = 0;
    s_valid = 1; s_data = 12'h321; step();
    s_data = 12'h654; step();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_addr", addr_w, 0);
    chk("mid_rst_pixel", pixel_out, 0);
    chk("mid_rst_ready", s_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_x0", x0, 0);
    chk("mid_rst_y0", y0, 0);
    s_valid = 0;
    step(); step();
    reset_n = 1'b1;
    clr_log();
    repeat (3) step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", s_ready, 0);
    frame_start = 1; step(); frame_start = 0; step();
    chk("post_rst_x0", x0, 0);
    chk("post_rst_y0", y0, 0);
    repeat (4) step();
    chk("post_rst_nwr", wa.size(), 0);
    chk("post_rst_ndone", done_t.size(), 0);

    do_clear(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
